// File: rtl/uart_pkg.sv
// uart_pkg: definitions shared by the UART receiver and transmitter.
//   uart_state_t          - receive/transmit FSM state encoding
//   UART_DATA_BITS        - data bits per frame (8N1)
//   UART_CLKS_PER_BIT     - default clocks per bit (100 MHz / 9600 baud)
package uart_pkg;

  localparam int UART_DATA_BITS    = 8;
  localparam int UART_CLKS_PER_BIT = 10417;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    STOP      = 3'd3,
    WAIT_HIGH = 3'd4
  } uart_state_t;

endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: two-flop synchronizer for a single asynchronous input.
//   clk   - destination clock
//   reset - asynchronous active-high reset; both flops load RESET_VAL
//   d     - asynchronous input
//   q     - synchronized output (two clk cycles of latency)
module sync_2ff #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_receiver.sv
// uart_receiver: 8N1 UART receiver, LSB first, mid-bit sampling.
//   clk         - system clock
//   reset       - asynchronous active-high reset
//   RxD         - asynchronous serial input, idle high
//   data        - last correctly framed word received (held between frames)
//   data_valid  - one-cycle pulse when data is updated
//   frame_error - one-cycle pulse when the stop bit is sampled low
//   busy        - high whenever the FSM is not idle
// CLKS_PER_BIT must be at least 2.
module uart_receiver
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT,
  parameter int DATA_BITS    = UART_DATA_BITS
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 RxD,
  output logic [DATA_BITS-1:0] data,
  output logic                 data_valid,
  output logic                 frame_error,
  output logic                 busy
);

  localparam int CNT_W  = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BIT_W  = $clog2(DATA_BITS + 1);
  localparam int HALF   = (CLKS_PER_BIT / 2 > 0) ? CLKS_PER_BIT / 2 : 1;

  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF - 1);
  localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(DATA_BITS - 1);

  uart_state_t          state;
  logic                 rx_s;
  logic [CNT_W-1:0]     baud_cnt;
  logic [BIT_W-1:0]     bit_cnt;
  logic [DATA_BITS-1:0] shift_reg;

  sync_2ff #(.RESET_VAL(1'b1)) u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (RxD),
    .q     (rx_s)
  );

  assign busy = (state != IDLE);

  // The baud counter returns to zero on every transition, so each state
  // measures its interval from the cycle it was entered.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      baud_cnt    <= '0;
      bit_cnt     <= '0;
      shift_reg   <= '0;
      data        <= '0;
      data_valid  <= 1'b0;
      frame_error <= 1'b0;
    end else begin
      data_valid  <= 1'b0;
      frame_error <= 1'b0;
      case (state)
        IDLE: begin
          baud_cnt <= '0;
          if (!rx_s) begin
            bit_cnt <= '0;
            state   <= START;
          end
        end
        START: begin
          if (baud_cnt == HALF_LAST) begin
            baud_cnt <= '0;
            // Line back high at mid start bit: treat as a glitch.
            state    <= rx_s ? IDLE : DATA;
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        DATA: begin
          if (baud_cnt == FULL_LAST) begin
            baud_cnt  <= '0;
            shift_reg <= {rx_s, shift_reg[DATA_BITS-1:1]};
            bit_cnt   <= bit_cnt + 1'b1;
            if (bit_cnt == BIT_LAST) state <= STOP;
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        STOP: begin
          if (baud_cnt == FULL_LAST) begin
            baud_cnt <= '0;
            if (rx_s) begin
              data       <= shift_reg;
              data_valid <= 1'b1;
              state      <= IDLE;
            end else begin
              frame_error <= 1'b1;
              state       <= WAIT_HIGH;
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        WAIT_HIGH: begin
          // A held-low (break) line must not be mistaken for a start bit.
          baud_cnt <= '0;
          if (rx_s) state <= IDLE;
        end
        default: begin
          baud_cnt <= '0;
          state    <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_receiver.sv
// tb_uart_receiver: randomized scoreboard bench for uart_receiver at
// CLKS_PER_BIT = 16. The stimulus side serializes bytes as 8N1 frames and
// queues the expected event; an independent monitor checks every pulse.
module tb_uart_receiver;

  localparam int CLKS = 16;
  localparam int DW   = 8;

  logic          clk;
  logic          reset;
  logic          RxD;
  logic [DW-1:0] data;
  logic          data_valid;
  logic          frame_error;
  logic          busy;

  typedef struct {
    bit            is_err;
    logic [DW-1:0] value;
  } exp_t;

  exp_t          exp_q[$];
  logic [DW-1:0] model_last;
  int            tests_run;
  int            tests_failed;
  int            rx_events;
  int            pushed;
  bit            prev_dv;

  uart_receiver #(.CLKS_PER_BIT(CLKS), .DATA_BITS(DW)) dut (
    .clk         (clk),
    .reset       (reset),
    .RxD         (RxD),
    .data        (data),
    .data_valid  (data_valid),
    .frame_error (frame_error),
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: pops one expectation per output pulse.
  always @(negedge clk) begin
    if (!reset) begin
      if (data_valid && frame_error)
        check("dv_fe_exclusive", 32'd1, 32'd0);
      if (data_valid && prev_dv)
        check("dv_one_cycle", 32'd1, 32'd0);
      if (data_valid || frame_error) begin
        rx_events++;
        if (exp_q.size() == 0) begin
          check("unexpected_pulse", {30'd0, data_valid, frame_error}, 32'd0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("pulse_kind", {30'd0, data_valid, frame_error},
                e.is_err ? 32'd1 : 32'd2);
          check(e.is_err ? "data_held_on_error" : "rx_data", {24'd0, data}, {24'd0, e.value});
        end
      end
      prev_dv = data_valid;
    end else begin
      prev_dv = 1'b0;
    end
  end

  task automatic hold(input logic b, input int n);
    RxD = b;
    repeat (n) @(negedge clk);
  endtask

  task automatic send_frame(input logic [DW-1:0] b, input logic stop_bit, input int gap);
    exp_t e;
    hold(1'b0, CLKS);
    for (int unsigned i = 0; i < DW; i++) hold(b[i], CLKS);
    if (stop_bit) model_last = b;
    e.is_err = !stop_bit;
    e.value  = model_last;
    exp_q.push_back(e);
    pushed++;
    hold(stop_bit, CLKS);
    if (gap > 0) hold(1'b1, gap);
  endtask

  task automatic check_drained(input string name);
    check(name, exp_q.size(), 32'd0);
  endtask

  initial begin
    int  wait_cycles;
    bit  busy_seen;
    tests_run    = 0;
    tests_failed = 0;
    rx_events    = 0;
    pushed       = 0;
    model_last   = '0;
    prev_dv      = 1'b0;
    reset        = 1'b1;
    RxD          = 1'b1;
    repeat (3) @(negedge clk);

    check("reset_data", {24'd0, data}, 32'd0);
    check("reset_dv", {31'd0, data_valid}, 32'd0);
    check("reset_fe", {31'd0, frame_error}, 32'd0);
    check("reset_busy", {31'd0, busy}, 32'd0);
    reset = 1'b0;
    hold(1'b1, 5);

    // Basic frame.
    send_frame(8'hA5, 1'b1, 4);
    check_drained("a5_drained");
    check("a5_data_held", {24'd0, data}, 32'hA5);

    // Short low glitch must be rejected.
    busy_seen = 1'b0;
    for (int unsigned i = 0; i < 4; i++) begin
      RxD = 1'b0;
      @(negedge clk);
      if (busy) busy_seen = 1'b1;
    end
    RxD = 1'b1;
    wait_cycles = 0;
    while (busy && wait_cycles < 12) begin
      @(negedge clk);
      if (busy) busy_seen = 1'b1;
      wait_cycles++;
    end
    check("glitch_busy_seen", {31'd0, busy_seen}, 32'd1);
    check("glitch_busy_clear", {31'd0, busy}, 32'd0);
    hold(1'b1, 20);
    check("glitch_data_held", {24'd0, data}, 32'hA5);

    // Framing error followed by a break.
    send_frame(8'h3C, 1'b0, 0);
    hold(1'b0, 40);
    check("break_busy", {31'd0, busy}, 32'd1);
    check_drained("fe_drained");
    hold(1'b1, 20);
    check("break_idle", {31'd0, busy}, 32'd0);
    check("fe_data_held", {24'd0, data}, 32'hA5);

    // Back-to-back frames, no idle between stop and start.
    send_frame(8'h00, 1'b1, 0);
    send_frame(8'hFF, 1'b1, 5);
    check_drained("b2b_drained");

    // Reset in the middle of data bit 3.
    hold(1'b0, CLKS);
    for (int unsigned i = 0; i < 3; i++) hold(i[0] ? 1'b1 : 1'b0, CLKS);
    hold(1'b1, CLKS / 2);
    reset = 1'b1;
    #1;
    check("midreset_data", {24'd0, data}, 32'd0);
    check("midreset_dv", {31'd0, data_valid}, 32'd0);
    check("midreset_fe", {31'd0, frame_error}, 32'd0);
    check("midreset_busy", {31'd0, busy}, 32'd0);
    model_last = '0;
    hold(1'b1, 4);
    reset = 1'b0;
    hold(1'b1, 4);
    send_frame(8'h5A, 1'b1, 3);
    check_drained("post_reset_drained");

    // Randomized frames, some with bad stop bits.
    for (int unsigned n = 0; n < 40; n++) begin
      logic [DW-1:0] b;
      logic          good;
      b    = DW'($urandom);
      good = ($urandom_range(0, 4) != 0);
      send_frame(b, good, good ? $urandom_range(0, 3) : 0);
      if (!good) hold(1'b1, 4 + $urandom_range(0, 6));
    end
    check_drained("random_drained");

    // Loopback sweep of every byte value.
    for (int unsigned v = 0; v < 256; v++)
      send_frame(DW'(v), 1'b1, $urandom_range(0, 2));
    hold(1'b1, 2 * CLKS);
    check_drained("sweep_drained");
    check("event_count", rx_events, pushed);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
